// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: channel state encoding and
// counter width helper.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, press/release pulses
// and held-key auto-repeat.
module button_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000,
    parameter int REPEAT_EN            = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DEB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY_CYCLES);
    localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD_CYCLES);

    btn_state_t       state;
    logic             s0, s1;
    logic [DEB_W-1:0] deb_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic [RPT_W-1:0] rpt_nxt;
    logic [RPT_W-1:0] rpt_target;

    // Counter restarts at zero on every repeat, so the period never drifts.
    assign rpt_nxt    = rpt_cnt + RPT_W'(1);
    assign rpt_target = rpt_first ? RPT_PERIOD : RPT_DELAY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            s0            <= 1'b0;
            s1            <= 1'b0;
            deb_cnt       <= '0;
            rpt_cnt       <= '0;
            rpt_first     <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            s0            <= btn;
            s1            <= s0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (s1) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state     <= HELD;
                            level     <= 1'b1;
                            press     <= 1'b1;
                            rpt_cnt   <= '0;
                            rpt_first <= 1'b0;
                        end else begin
                            state   <= PRESS_PEND;
                            deb_cnt <= DEB_W'(1);
                        end
                    end
                end
                PRESS_PEND: begin
                    if (!s1) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= HELD;
                        level     <= 1'b1;
                        press     <= 1'b1;
                        deb_cnt   <= '0;
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                HELD: begin
                    if (!s1) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state         <= IDLE;
                            level         <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            state   <= RELEASE_PEND;
                            deb_cnt <= DEB_W'(1);
                        end
                    end else if (REPEAT_EN != 0) begin
                        if (rpt_nxt == rpt_target) begin
                            repeat_pulse <= 1'b1;
                            rpt_cnt      <= '0;
                            rpt_first    <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_nxt;
                        end
                    end
                end
                RELEASE_PEND: begin
                    // A bounce back to pressed resumes the hold with rpt_cnt intact.
                    if (s1) begin
                        state   <= HELD;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= IDLE;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                        deb_cnt       <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions WIDTH raw button pins into debounced levels plus press, release
// and auto-repeat pulses.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int WIDTH                = 5,
    parameter int ACTIVE_LOW           = 0,
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000,
    parameter int REPEAT_EN            = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] press_rpt
);

    logic [WIDTH-1:0] btn_pol;

    assign btn_pol   = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;
    assign press_rpt = press | repeat_pulse;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
            .REPEAT_EN           (REPEAT_EN)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn          (btn_pol[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed tables/sequences plus random pin
// activity, all checked against a run-length reference model.
module tb_button_conditioner;

    localparam int W   = 5;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] btn_a, btn_b;
    logic [W-1:0] lvl_a, prs_a, rel_a, rpt_a, prp_a;
    logic [W-1:0] lvl_b, prs_b, rel_b, rpt_b, prp_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    button_conditioner #(
        .WIDTH(W), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY_CYCLES(DLY), .REPEAT_PERIOD_CYCLES(PER), .REPEAT_EN(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_a), .level(lvl_a), .press(prs_a),
        .release_pulse(rel_a), .repeat_pulse(rpt_a), .press_rpt(prp_a)
    );

    button_conditioner #(
        .WIDTH(W), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY_CYCLES(DLY), .REPEAT_PERIOD_CYCLES(PER), .REPEAT_EN(1)
    ) u_al (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_b), .level(lvl_b), .press(prs_b),
        .release_pulse(rel_b), .repeat_pulse(rpt_b), .press_rpt(prp_b)
    );

    // Reference model: a change is accepted after DEB consecutive synced
    // samples disagree with the level; repeats fall at hold counts DLY+n*PER.
    logic [W-1:0] m_s0 [2], m_s1 [2], m_lvl [2], m_prs [2], m_rel [2], m_rpt [2];
    int           m_run [2][W];
    int           m_held [2][W];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s0[k] = '0; m_s1[k] = '0; m_lvl[k] = '0;
            m_prs[k] = '0; m_rel[k] = '0; m_rpt[k] = '0;
            for (int c = 0; c < W; c++) begin
                m_run[k][c]  = 0;
                m_held[k][c] = 0;
            end
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] pins;
        for (int k = 0; k < 2; k++) begin
            pins = (k == 0) ? btn_a : ~btn_b;
            m_prs[k] = '0; m_rel[k] = '0; m_rpt[k] = '0;
            for (int c = 0; c < W; c++) begin
                if (m_s1[k][c] != m_lvl[k][c]) begin
                    m_run[k][c]++;
                    if (m_run[k][c] == DEB) begin
                        m_run[k][c] = 0;
                        m_lvl[k][c] = ~m_lvl[k][c];
                        if (m_lvl[k][c]) begin
                            m_prs[k][c]  = 1'b1;
                            m_held[k][c] = 0;
                        end else begin
                            m_rel[k][c] = 1'b1;
                        end
                    end
                end else begin
                    if (m_lvl[k][c] && m_run[k][c] == 0) begin
                        m_held[k][c]++;
                        if (m_held[k][c] >= DLY && (m_held[k][c] - DLY) % PER == 0)
                            m_rpt[k][c] = 1'b1;
                    end
                    m_run[k][c] = 0;
                end
            end
            m_s1[k] = m_s0[k];
            m_s0[k] = pins;
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("model_level_a",  lvl_a, m_lvl[0]);
        chk("model_press_a",  prs_a, m_prs[0]);
        chk("model_rel_a",    rel_a, m_rel[0]);
        chk("model_rpt_a",    rpt_a, m_rpt[0]);
        chk("model_prsrpt_a", prp_a, m_prs[0] | m_rpt[0]);
        chk("model_level_b",  lvl_b, m_lvl[1]);
        chk("model_press_b",  prs_b, m_prs[1]);
        chk("model_rel_b",    rel_b, m_rel[1]);
        chk("model_rpt_b",    rpt_b, m_rpt[1]);
        chk("model_prsrpt_b", prp_b, m_prs[1] | m_rpt[1]);
    endtask

    // One clock: model advances at the edge, outputs compared at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic assert_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_level_a", lvl_a, '0);
        chk("rst_press_a", prs_a | rel_a | rpt_a | prp_a, '0);
        chk("rst_level_b", lvl_b, '0);
        chk("rst_press_b", prs_b | rel_b | rpt_b | prp_b, '0);
        cycles(n);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] btn;
        logic [W-1:0] lvl;
        logic [W-1:0] prs;
        logic [W-1:0] rel;
    } vec_t;

    vec_t         tbl [16];
    logic [13:0]  bp;
    int           dur_a [W];
    int           dur_b [W];

    initial begin
        // Clean press held 8 cycles: pulses land 6 edges after each pin change.
        for (int i = 0; i < 16; i++) begin
            tbl[i].btn = (i < 8)            ? 5'b00001 : 5'b00000;
            tbl[i].lvl = (i >= 5 && i < 13) ? 5'b00001 : 5'b00000;
            tbl[i].prs = (i == 5)           ? 5'b00001 : 5'b00000;
            tbl[i].rel = (i == 13)          ? 5'b00001 : 5'b00000;
        end

        rst_n = 1'b0;
        btn_a = '0;
        btn_b = '1;
        model_reset();
        @(negedge clk);
        assert_reset(3);
        cycles(4);

        // Test 1: table
        for (int i = 0; i < 16; i++) begin
            btn_a = tbl[i].btn;
            cycle();
            chk("t1_level",   lvl_a, tbl[i].lvl);
            chk("t1_press",   prs_a, tbl[i].prs);
            chk("t1_release", rel_a, tbl[i].rel);
            chk("t1_repeat",  rpt_a, '0);
        end

        // Test 2: bouncy press on channel 2, final 0->1 at index 5
        bp = 14'b11111111101101;
        for (int i = 0; i < 14; i++) begin
            btn_a[2] = bp[i];
            cycle();
            chk1("t2_press",   prs_a[2], i == 10);
            chk1("t2_release", rel_a[2], 1'b0);
        end
        btn_a[2] = 1'b0;
        cycles(8);

        // Test 3: hold channel 4, repeats at press+10,13,...,28
        btn_a[4] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk1("t3_press", prs_a[4], i == 6);
        end
        for (int j = 1; j <= 28; j++) begin
            cycle();
            chk1("t3_repeat",    rpt_a[4], j == 10 || j == 13 || j == 16 || j == 19 ||
                                           j == 22 || j == 25 || j == 28);
            chk1("t3_press_rpt", prp_a[4], j == 10 || j == 13 || j == 16 || j == 19 ||
                                           j == 22 || j == 25 || j == 28);
        end
        btn_a[4] = 1'b0;
        for (int j = 29; j <= 40; j++) begin
            cycle();
            chk1("t3_no_repeat", rpt_a[4], 1'b0);
            chk1("t3_release",   rel_a[4], j == 34);
        end

        // Test 4: simultaneous press on 1 and 3, release only 1
        btn_a[1] = 1'b1;
        btn_a[3] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk("t4_press", prs_a, (i == 6) ? 5'b01010 : 5'b00000);
        end
        cycles(3);
        btn_a[1] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk("t4_release", rel_a, (i == 6) ? 5'b00010 : 5'b00000);
            chk1("t4_level3", lvl_a[3], 1'b1);
        end
        btn_a[3] = 1'b0;
        cycles(12);

        // Test 5: reset while held, pin still pressed when reset lifts
        btn_a[0] = 1'b1;
        cycles(8);
        chk1("t5_held", lvl_a[0], 1'b1);
        assert_reset(3);
        chk1("t5_no_release", rel_a[0], 1'b0);
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk1("t5_press", prs_a[0], i == 6);
        end
        btn_a[0] = 1'b0;
        cycles(8);

        // Test 6: active-low instance idles at all ones
        chk("t6_idle_level", lvl_b, '0);
        btn_b[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            chk1("t6_press", prs_b[0], i == 6);
        end
        btn_b[0] = 1'b1;
        cycles(8);

        // Random pin activity with a mix of bounces and long holds
        for (int c = 0; c < W; c++) begin
            dur_a[c] = $urandom_range(1, 20);
            dur_b[c] = $urandom_range(1, 20);
        end
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < W; c++) begin
                if (--dur_a[c] == 0) begin
                    btn_a[c] = ~btn_a[c];
                    dur_a[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(4, 40);
                end
                if (--dur_b[c] == 0) begin
                    btn_b[c] = ~btn_b[c];
                    dur_b[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(4, 40);
                end
            end
            if ($urandom_range(0, 499) == 0) assert_reset($urandom_range(1, 3));
            else                             cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
